sha256_stream_core: RTL and testbench
=====================================

SHA256_STREAM_CORE -- requirements
Module: sha256_stream_core

Interface
REQ-001 SHALL have parameter UNROLL, default 1, meaning rounds per compression cycle; legal values 1, 2, 4.
REQ-002 SHALL have parameter CHAIN_EN, default 1; 1 means multi-block chaining is supported, 0 means every block loads the IV.
REQ-003 SHALL have port CLK  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port nreset  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port block_valid  input  1  block_data and block_first are valid.
REQ-006 SHALL have port block_ready  output  1  core accepts a block this cycle.
REQ-007 SHALL have port block_first  input  1  1 means start a new message with the IV; 0 means continue from the current H.
REQ-008 SHALL have port block_data  input  512  one padded block; bits [511:480] = W0 ... [31:0] = W15, big-endian words.
REQ-009 SHALL have port digest  output  256  registered H; bits [255:224] = H0 ... [31:0] = H7.
REQ-010 SHALL have port digest_valid  output  1  one-cycle pulse when digest is updated.
REQ-011 SHALL have port busy  output  1  high in ROUND and FINAL.

Function
REQ-012 SHALL implement a three-state FSM: IDLE, ROUND, FINAL.
REQ-013 SHALL drive block_ready = 1 only in IDLE; a block is accepted on an edge where block_valid && block_ready.
REQ-014 SHALL, on acceptance: load W[0..15] from block_data; load a..h from the IV if block_first=1 or CHAIN_EN=0, else from H; also load H from the IV when a..h take the IV; clear round counter; go to ROUND.
REQ-015 SHALL perform UNROLL consecutive SHA-256 rounds per ROUND cycle, each with K[t] and W[t] for t = round counter + 0..UNROLL-1.
REQ-016 SHALL, for t >= 16, generate W[t] = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16] mod 2^32 in a 16-word sliding window advancing UNROLL words per cycle.
REQ-017 SHALL advance the round counter (7 bits) by UNROLL per ROUND cycle and go to FINAL on the cycle that completes round 63.
REQ-018 SHALL, in FINAL, set H[i] <= H[i] + {a..h}[i] mod 2^32, set digest <= new H, pulse digest_valid for exactly one cycle, and return to IDLE.
REQ-019 SHALL have a latency of 64/UNROLL + 1 cycles from the accept edge to digest_valid high (65 / 33 / 17).
REQ-020 SHALL ignore block_valid while busy; there is no input buffering, and block_data need not be held after acceptance.
REQ-021 SHALL accept a new block in the IDLE cycle that coincides with digest_valid high, giving a back-to-back throughput of one block per 64/UNROLL + 2 cycles.
REQ-022 SHALL hold digest stable between digest_valid pulses.
REQ-023 SHALL, when block_first=0 is the first block after reset, chain from the reset H (the IV), so the result equals a block_first=1 hash.
REQ-024 SHALL perform all additions as 32-bit, wrap-around, with no saturation.

Reset
REQ-025 SHALL, on nreset low, asynchronously force: state=IDLE, round counter=0, H=IV, digest=0, digest_valid=0, busy=0.
REQ-026 SHALL, on reset mid-operation, abandon the block with no digest_valid pulse; after release, block_ready=1 in the first cycle.
REQ-027 SHALL leave W and a..h without reset; they are don't-care in IDLE.

Structure
REQ-028 SHALL place the IV constants H0..H7, the 64-entry K table, and the s0/s1/S0/S1/Ch/Maj functions in a shared package sha256_pkg.
REQ-029 SHALL instantiate UNROLL copies of a combinational sub-module sha256_round; the W scheduler and FSM stay in sha256_stream_core.

Verification
REQ-030 The bench SHALL cover "abc": block 61626380, then 0 x 14 words, then 00000018, with first=1 -> digest ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad, after 65 cycles (UNROLL=1).
REQ-031 The bench SHALL cover the empty message: block 80000000 followed by zeros, first=1 -> digest e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
REQ-032 The bench SHALL cover the two-block message "abcdbcdecdef...nopq" (448 bits), blocks sent with first=1 then first=0 -> final digest 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1; the intermediate digest_valid also pulses.
REQ-033 The bench SHALL cover back-to-back operation: "abc" then empty, each with first=1, the second presented during the digest_valid cycle -> both digests correct, second accepted in that cycle.
REQ-034 The bench SHALL cover reset mid-operation: nreset low at round 30 of "abc" -> no digest_valid; digest=0; then "abc" resent -> correct digest.
REQ-035 The bench SHALL repeat REQ-030 and REQ-032 with UNROLL=2 and UNROLL=4 -> identical digests at latency 33 and 17.

Source files
------------

// File: rtl/sha256_pkg.sv
// SHA-256 constants (IV, round constants) and the bitwise helper functions
// shared by the round datapath and the message scheduler.
package sha256_pkg;

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_FINAL} state_t;

  // H0 sits in the top word, H7 in the bottom word.
  localparam logic [255:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Message-schedule sigmas
  function automatic logic [31:0] small_s0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_s1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Compression-round Sigmas
  function automatic logic [31:0] big_s0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_s1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f, input logic [31:0] g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 round: {a..h} in, {a..h} out, a in the top word.
module sha256_round
  import sha256_pkg::*;
(
  input  logic [255:0] i_state,
  input  logic [31:0]  i_k,
  input  logic [31:0]  i_w,
  output logic [255:0] o_state
);

  logic [31:0] w_a, w_b, w_c, w_d, w_e, w_f, w_g, w_h;
  logic [31:0] w_t1, w_t2;

  assign {w_a, w_b, w_c, w_d, w_e, w_f, w_g, w_h} = i_state;
  assign w_t1    = w_h + big_s1(w_e) + ch(w_e, w_f, w_g) + i_k + i_w;
  assign w_t2    = big_s0(w_a) + maj(w_a, w_b, w_c);
  assign o_state = {w_t1 + w_t2, w_a, w_b, w_c, w_d + w_t1, w_e, w_f, w_g};

endmodule

// File: rtl/sha256_stream_core.sv
// Iterative SHA-256 compression core: one 512-bit block in, chained H out.
// UNROLL (1, 2 or 4) rounds run per ROUND cycle; a 16-word sliding window
// produces the message schedule on the fly.
module sha256_stream_core
  import sha256_pkg::*;
#(
  parameter int UNROLL   = 1,
  parameter int CHAIN_EN = 1
) (
  input  logic         CLK,
  input  logic         nreset,
  input  logic         block_valid,
  output logic         block_ready,
  input  logic         block_first,
  input  logic [511:0] block_data,
  output logic [255:0] digest,
  output logic         digest_valid,
  output logic         busy
);

  state_t       r_state, w_nstate;
  logic [6:0]   r_rnd;
  logic [255:0] r_h, r_digest, r_v;
  logic         r_dv;
  logic [31:0]  r_w [0:15];

  logic [31:0]  w_ext [0:15+UNROLL];
  logic [255:0] w_next_v, w_hsum;
  logic         w_accept, w_use_iv, w_last;

  assign w_use_iv     = block_first || (CHAIN_EN == 0);
  assign w_last       = (r_rnd == 7'(64 - UNROLL));
  assign block_ready  = (r_state == S_IDLE);
  assign busy         = (r_state != S_IDLE);
  assign digest       = r_digest;
  assign digest_valid = r_dv;

  // Schedule window extended by UNROLL new words; word i+16 depends on
  // words already in the array, so later words may use earlier new ones.
  always_comb begin
    for (int i = 0; i < 16; i++) w_ext[i] = r_w[i];
    for (int i = 16; i < 16 + UNROLL; i++)
      w_ext[i] = small_s1(w_ext[i-2]) + w_ext[i-7] + small_s0(w_ext[i-15]) + w_ext[i-16];
  end

  // Chain of UNROLL rounds; round g uses K[t+g] and window word g.
  for (genvar g = 0; g < UNROLL; g++) begin : g_rnd
    logic [255:0] w_in, w_out;
    logic [5:0]   w_kidx;
    if (g == 0) begin : g_first
      assign w_in = r_v;
    end else begin : g_next
      assign w_in = g_rnd[g-1].w_out;
    end
    assign w_kidx = r_rnd[5:0] + 6'(g);
    sha256_round u_round (
      .i_state (w_in),
      .i_k     (K[w_kidx]),
      .i_w     (w_ext[g]),
      .o_state (w_out)
    );
  end
  assign w_next_v = g_rnd[UNROLL-1].w_out;

  // Feed-forward: per-word wrap-around add of working vars into H.
  always_comb begin
    w_hsum = '0;
    for (int i = 0; i < 8; i++) w_hsum[32*i +: 32] = r_h[32*i +: 32] + r_v[32*i +: 32];
  end

  // Next-state logic: IDLE -> ROUND on accept, ROUND -> FINAL after round 63.
  always_comb begin
    w_nstate = r_state;
    w_accept = 1'b0;
    case (r_state)
      S_IDLE: if (block_valid) begin
        w_nstate = S_ROUND;
        w_accept = 1'b1;
      end
      S_ROUND: if (w_last) w_nstate = S_FINAL;
      S_FINAL: w_nstate = S_IDLE;
      default: w_nstate = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK or negedge nreset) begin
    if (!nreset) r_state <= S_IDLE;
    else         r_state <= w_nstate;
  end

  // Round counter, chaining value and digest output register.
  always_ff @(posedge CLK or negedge nreset) begin
    if (!nreset) begin
      r_rnd    <= '0;
      r_h      <= IV;
      r_digest <= '0;
      r_dv     <= 1'b0;
    end else begin
      r_dv <= 1'b0;
      if (w_accept) begin
        r_rnd <= '0;
        if (w_use_iv) r_h <= IV;
      end else if (r_state == S_ROUND) begin
        r_rnd <= r_rnd + 7'(UNROLL);
      end else if (r_state == S_FINAL) begin
        r_h      <= w_hsum;
        r_digest <= w_hsum;
        r_dv     <= 1'b1;
      end
    end
  end

  // Working variables and schedule window; meaningless while idle, so no reset.
  always_ff @(posedge CLK) begin
    if (w_accept) begin
      r_v <= w_use_iv ? IV : r_h;
      for (int i = 0; i < 16; i++) r_w[i] <= block_data[511-32*i -: 32];
    end else if (r_state == S_ROUND) begin
      r_v <= w_next_v;
      for (int i = 0; i < 16; i++) r_w[i] <= w_ext[i+UNROLL];
    end
  end

endmodule

// File: tb/tb_sha256_stream_core.sv
// Bench for sha256_stream_core: four instances (UNROLL 1/2/4 with chaining,
// UNROLL 1 without chaining) checked every cycle against a behavioural
// SHA-256 model, plus literal FIPS digests.
module tb_sha256_stream_core;

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [255:0] IV_T = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

  localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
  localparam logic [511:0] BLK_2A = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f, 32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] BLK_2B = {480'h0, 32'h000001c0};

  localparam logic [255:0] DIG_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] DIG_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] DIG_2BLK  = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  logic CLK = 1'b0;
  logic nreset;
  logic go = 1'b0;
  always #5 CLK = ~CLK;

  logic         bv [4];
  logic         bf [4];
  logic [511:0] bd [4];
  logic         br [4];
  logic         dv [4];
  logic         bz [4];
  logic [255:0] dg [4];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    sha256_stream_core #(
      .UNROLL   ((g == 3) ? 1 : (1 << g)),
      .CHAIN_EN ((g == 3) ? 0 : 1)
    ) u_dut (
      .CLK          (CLK),
      .nreset       (nreset),
      .block_valid  (bv[g]),
      .block_ready  (br[g]),
      .block_first  (bf[g]),
      .block_data   (bd[g]),
      .digest       (dg[g]),
      .digest_valid (dv[g]),
      .busy         (bz[g])
    );
  end

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic int unr(input int k);
    return (k == 3) ? 1 : (1 << k);
  endfunction

  function automatic int lat(input int k);
    return 64 / unr(k) + 1;
  endfunction

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Straight FIPS 180-4 compression of one block onto chaining value hin.
  function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] h [8];
    logic [31:0] v [8];
    logic [31:0] t1, t2;
    logic [255:0] res;
    for (int i = 0; i < 8; i++) h[i] = hin[255-32*i -: 32];
    for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
    for (int t = 16; t < 64; t++)
      w[t] = (rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
           + (rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
    for (int i = 0; i < 8; i++) v[i] = h[i];
    for (int t = 0; t < 64; t++) begin
      t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
      t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int i = 7; i > 0; i--) v[i] = v[i-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) res[255-32*i -: 32] = h[i] + v[i];
    return res;
  endfunction

  function automatic logic [511:0] rnd512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // Behavioural model: per instance, remaining cycles of the current block,
  // pending result, chaining value and expected outputs.
  int           m_cnt  [4];
  logic [255:0] m_h    [4];
  logic [255:0] m_pend [4];
  logic [255:0] m_dig  [4];
  logic         m_dv   [4];

  always @(posedge CLK or negedge nreset) begin
    for (int k = 0; k < 4; k++) begin
      if (!nreset) begin
        m_cnt[k] <= 0;
        m_h[k]   <= IV_T;
        m_dig[k] <= '0;
        m_dv[k]  <= 1'b0;
      end else if (m_cnt[k] != 0) begin
        m_cnt[k] <= m_cnt[k] - 1;
        m_dv[k]  <= (m_cnt[k] == 1);
        if (m_cnt[k] == 1) begin
          m_h[k]   <= m_pend[k];
          m_dig[k] <= m_pend[k];
        end
      end else begin
        m_dv[k] <= 1'b0;
        if (bv[k]) begin
          m_pend[k] <= compress((bf[k] || k == 3) ? IV_T : m_h[k], bd[k]);
          m_cnt[k]  <= lat(k);
        end
      end
    end
  end

  // Every-cycle comparison of all instance outputs against the model.
  always @(negedge CLK) begin
    if (go) begin
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("u%0d_ready", k),  256'(br[k]), 256'(m_cnt[k] == 0));
        chk($sformatf("u%0d_busy", k),   256'(bz[k]), 256'(m_cnt[k] != 0));
        chk($sformatf("u%0d_dvalid", k), 256'(dv[k]), 256'(m_dv[k]));
        chk($sformatf("u%0d_digest", k), dg[k], m_dig[k]);
      end
    end
  end

  // Present a block right now (at a negedge) and drop valid after the accept edge.
  task automatic send_now(input int k, input logic f, input logic [511:0] d);
    bv[k] = 1'b1;
    bf[k] = f;
    bd[k] = d;
    @(negedge CLK);
    bv[k] = 1'b0;
    bf[k] = 1'($urandom);
    bd[k] = rnd512();
  endtask

  task automatic send(input int k, input logic f, input logic [511:0] d);
    int c;
    c = 0;
    @(negedge CLK);
    while (!br[k] && c < 300) begin
      @(negedge CLK);
      c++;
    end
    chk($sformatf("u%0d_ready_wait", k), 256'(br[k]), 256'(1));
    send_now(k, f, d);
  endtask

  // Counts cycles from the negedge after the accept edge to digest_valid.
  task automatic wait_dv(input int k, output int c);
    c = 0;
    while (!dv[k] && c < 200) begin
      @(negedge CLK);
      c++;
    end
  endtask

  task automatic run_lit(input int k, input logic f, input logic [511:0] d,
                         input logic [255:0] exp, input string name);
    int c;
    send(k, f, d);
    wait_dv(k, c);
    chk($sformatf("u%0d_%s_latency", k, name), 256'(c), 256'(lat(k)));
    chk($sformatf("u%0d_%s_digest", k, name), dg[k], exp);
  endtask

  initial begin
    int c, j, k, seen;
    logic [511:0] blk;
    for (int i = 0; i < 4; i++) begin
      bv[i] = 1'b0;
      bf[i] = 1'b0;
      bd[i] = '0;
    end
    nreset = 1'b0;
    repeat (3) @(negedge CLK);
    go = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("u%0d_rst_digest", i), dg[i], 256'h0);
      chk($sformatf("u%0d_rst_ready", i), 256'(br[i]), 256'(1));
    end
    #1 nreset = 1'b1;

    // Pin the model to the published vectors.
    chk("model_abc",   compress(IV_T, BLK_ABC), DIG_ABC);
    chk("model_empty", compress(IV_T, BLK_EMPTY), DIG_EMPTY);
    chk("model_2blk",  compress(compress(IV_T, BLK_2A), BLK_2B), DIG_2BLK);

    // First block after reset with first=0 chains from the reset IV.
    run_lit(0, 1'b0, BLK_ABC, DIG_ABC, "abc_nofirst");
    run_lit(0, 1'b1, BLK_EMPTY, DIG_EMPTY, "empty");

    // "abc" and the two-block message on every unroll factor.
    for (int u = 0; u < 3; u++) begin
      run_lit(u, 1'b1, BLK_ABC, DIG_ABC, "abc");
      send(u, 1'b1, BLK_2A);
      wait_dv(u, c);
      chk($sformatf("u%0d_2blk_mid_latency", u), 256'(c), 256'(lat(u)));
      run_lit(u, 1'b0, BLK_2B, DIG_2BLK, "2blk");
    end

    // Without chaining, a first=0 block still starts from the IV.
    run_lit(3, 1'b1, BLK_2A, compress(IV_T, BLK_2A), "nochain_a");
    run_lit(3, 1'b0, BLK_ABC, DIG_ABC, "nochain_abc");

    // Back-to-back: second block offered in the digest_valid cycle.
    run_lit(0, 1'b1, BLK_ABC, DIG_ABC, "b2b_first");
    chk("u0_b2b_ready_in_dv", 256'({dv[0], br[0]}), 256'(2'b11));
    send_now(0, 1'b1, BLK_EMPTY);
    chk("u0_b2b_accepted", 256'(bz[0]), 256'(1));
    wait_dv(0, c);
    chk("u0_b2b_latency", 256'(c), 256'(65));
    chk("u0_b2b_digest", dg[0], DIG_EMPTY);

    // Reset at round 30: no digest, digest cleared, ready straight after release.
    send(0, 1'b1, BLK_ABC);
    repeat (30) @(negedge CLK);
    #1 nreset = 1'b0;
    seen = 0;
    repeat (3) begin
      @(negedge CLK);
      if (dv[0]) seen++;
    end
    chk("u0_midrst_digest", dg[0], 256'h0);
    #1 nreset = 1'b1;
    @(negedge CLK);
    chk("u0_midrst_ready", 256'(br[0]), 256'(1));
    repeat (70) begin
      @(negedge CLK);
      if (dv[0]) seen++;
    end
    chk("u0_midrst_no_dvalid", 256'(seen), 256'(0));
    run_lit(0, 1'b0, BLK_ABC, DIG_ABC, "abc_after_rst");

    // Random blocks, random first flags, junk valid while busy.
    for (int it = 0; it < 40; it++) begin
      k   = $urandom_range(0, 3);
      blk = rnd512();
      send(k, 1'($urandom), blk);
      j = $urandom_range(0, 8);
      for (int i = 0; i < j; i++) begin
        bv[k] = 1'b1;
        bf[k] = 1'($urandom);
        bd[k] = rnd512();
        @(negedge CLK);
      end
      bv[k] = 1'b0;
      wait_dv(k, c);
      chk($sformatf("u%0d_rand%0d_latency", k, it), 256'(c + j), 256'(lat(k)));
    end

    @(negedge CLK);
    go = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit, got %0d/%0d", n_pass, n_tot);
    $fatal(1);
  end

endmodule
